// File: rtl/inst_decode_stage.sv
// RV32I decode stage: opcode -> immediate format, registered behind a two-entry skid buffer.
// Optional DECODE_CSR_EN: decode SYSTEM opcode (CSR immediates) instead of flagging it illegal.
module inst_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [2:0]  out_fmt,
    output logic        out_illegal
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_CSR = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } beat_t;

    fmt_e        dec_fmt;
    logic [31:0] dec_imm;
    beat_t       in_beat;
    logic        accept;

    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;

    always_comb begin
        dec_fmt = FMT_ILL;
        unique case (in_inst[6:0])
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111:             dec_fmt = FMT_J;
            7'b1100111, 7'b0000011,
            7'b0010011, 7'b0001111: dec_fmt = FMT_I;
            7'b1100011:             dec_fmt = FMT_B;
            7'b0100011:             dec_fmt = FMT_S;
            7'b0110011:             dec_fmt = FMT_R;
            7'b1110011: begin
`ifdef DECODE_CSR_EN
                dec_fmt = in_inst[14] ? FMT_CSR : FMT_I;
`else
                dec_fmt = FMT_ILL;
`endif
            end
            default:                dec_fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        dec_imm = '0;
        unique case (dec_fmt)
            FMT_I:   dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S:   dec_imm = {{20{in_inst[31]}}, in_inst[31:25],
                                in_inst[11:7]};
            FMT_B:   dec_imm = {{19{in_inst[31]}}, in_inst[31],
                                in_inst[7], in_inst[30:25],
                                in_inst[11:8], 1'b0};
            FMT_U:   dec_imm = {in_inst[31:12], 12'b0};
            FMT_J:   dec_imm = {{11{in_inst[31]}}, in_inst[31],
                                in_inst[19:12], in_inst[20],
                                in_inst[30:21], 1'b0};
            FMT_CSR: dec_imm = {27'b0, in_inst[19:15]};
            default: dec_imm = '0;
        endcase
    end

    assign in_beat = '{inst: in_inst,
                       pc:   in_pc,
                       imm:  dec_imm,
                       fmt:  dec_fmt,
                       ill:  (dec_fmt == FMT_ILL)};

    assign accept = in_valid && !skid_valid_q;

    // Skid can only be occupied while main is stalled, so it never coexists
    // with an accept; draining always promotes skid before taking new input.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_beat;
                end
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign out_inst    = main_q.inst;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed cases then random traffic
// against a queue-based model with an arithmetic immediate reference.
module tb_inst_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } mbeat_t;

    mbeat_t q[$];

    inst_decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference immediates built from field values as signed integers.
    function automatic void ref_dec(input logic [31:0] i,
                                    output logic [2:0] f,
                                    output logic [31:0] m);
        longint v;
        v = 0;
        f = 3'd7;
        case (i[6:0])
            7'h37, 7'h17: begin
                f = 3'd4;
                v = longint'(i[31:12]) * 4096;
            end
            7'h6F: begin
                f = 3'd5;
                v = longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096
                  + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            7'h67, 7'h03, 7'h13, 7'h0F: f = 3'd1;
            7'h63: begin
                f = 3'd3;
                v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                  + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h23: begin
                f = 3'd2;
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'h33: f = 3'd0;
            7'h73: begin
`ifdef DECODE_CSR_EN
                if (i[14]) begin
                    f = 3'd6;
                    v = longint'(i[19:15]);
                end else begin
                    f = 3'd1;
                end
`else
                f = 3'd7;
`endif
            end
            default: f = 3'd7;
        endcase
        if (f == 3'd1) begin
            v = longint'(i[31:20]);
            if (v >= 2048) v -= 4096;
        end
        m = 32'(v);
    endfunction

    task automatic model_edge();
        bit fin, fout;
        if (flush) begin
            q.delete();
        end else begin
            fin  = in_valid && (q.size() < 2);
            fout = (q.size() > 0) && out_ready;
            if (fout) void'(q.pop_front());
            if (fin) q.push_back('{inst: in_inst, pc: in_pc});
        end
    endtask

    task automatic compare_all();
        logic [2:0]  f;
        logic [31:0] m;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            ref_dec(q[0].inst, f, m);
            check("out_inst", out_inst, q[0].inst);
            check("out_pc", out_pc, q[0].pc);
            check("out_imm", out_imm, m);
            check("out_fmt", 32'(out_fmt), 32'(f));
            check("out_illegal", 32'(out_illegal), 32'(f == 3'd7));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] inst,
                        input logic [31:0] pc, input logic ordy,
                        input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [0:9];
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                7'h13, 7'h0F, 7'h63, 7'h23, 7'h33};
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 10) r[6:0] = ops[k];
        else if (k == 10) r[6:0] = 7'h73;
        return r;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_inst", out_inst, 32'd0);
        check("rst out_pc", out_pc, 32'd0);
        check("rst out_imm", out_imm, 32'd0);
        check("rst out_fmt", 32'(out_fmt), 32'd0);
        check("rst out_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
        check("addi fmt", 32'(out_fmt), 32'd1);
        check("addi imm", out_imm, 32'hFFFFFFFF);
        step(1'b1, 32'hFE000EE3, 32'h104, 1'b1, 1'b0);
        check("beq fmt", 32'(out_fmt), 32'd3);
        check("beq imm", out_imm, 32'hFFFFFFFC);
        step(1'b1, 32'h00112623, 32'h108, 1'b1, 1'b0);
        check("sw fmt", 32'(out_fmt), 32'd2);
        check("sw imm", out_imm, 32'h0000000C);
        step(1'b1, 32'h123450B7, 32'h10C, 1'b1, 1'b0);
        check("lui fmt", 32'(out_fmt), 32'd4);
        check("lui imm", out_imm, 32'h12345000);
        step(1'b1, 32'h3002D073, 32'h110, 1'b1, 1'b0);
`ifdef DECODE_CSR_EN
        check("csr fmt", 32'(out_fmt), 32'd6);
        check("csr imm", out_imm, 32'h5);
        check("csr ill", 32'(out_illegal), 32'd0);
`else
        check("csr fmt", 32'(out_fmt), 32'd7);
        check("csr imm", out_imm, 32'h0);
        check("csr ill", 32'(out_illegal), 32'd1);
`endif
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // stall: A, B absorbed, C held until release
        step(1'b1, 32'h00A00093, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h00B00093, 32'h204, 1'b0, 1'b0);
        check("stall ready", 32'(in_ready), 32'd0);
        step(1'b1, 32'h00C00093, 32'h208, 1'b0, 1'b0);
        check("stall hold A", out_inst, 32'h00A00093);
        step(1'b1, 32'h00C00093, 32'h208, 1'b1, 1'b0);
        check("release B", out_inst, 32'h00B00093);
        step(1'b1, 32'h00C00093, 32'h208, 1'b1, 1'b0);
        check("release C", out_inst, 32'h00C00093);
        check("release C valid", 32'(out_valid), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // flush with A, B buffered while C offered
        step(1'b1, 32'h00A00093, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h00B00093, 32'h304, 1'b0, 1'b0);
        step(1'b1, 32'h00C00093, 32'h308, 1'b0, 1'b1);
        check("flush valid", 32'(out_valid), 32'd0);
        check("flush ready", 32'(in_ready), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // asynchronous reset mid-stall
        step(1'b1, 32'h00A00093, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h00B00093, 32'h404, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst valid", 32'(out_valid), 32'd0);
        check("arst ready", 32'(in_ready), 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h0FF00513, 32'h500, 1'b1, 1'b0);
        check("post-rst valid", 32'(out_valid), 32'd1);
        check("post-rst inst", out_inst, 32'h0FF00513);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, rand_inst(), $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
